usb_packet_rx: RTL and testbench
================================

Name: usb_packet_rx

Overview:
- USB packet-layer receiver, one per device core.
- Sits between the bit-level receiver (which has already done NRZI decode, bit-unstuffing and SYNC/EOP detection) and the protocol engine.
- Accumulates the LSB-first serial bit stream, decodes and checks the PID, and extracts the token address/endpoint field or streams data-packet bytes.
- Checks CRC5/CRC16 and reports packet validity at packet end.

Parameters:
None (USB field widths and CRC polynomials are fixed by the standard; constants live in the shared package).

Ports:
clk  input  1  system clock (60 MHz)
rst_n  input  1  reset, synchronous, active-low
rx_start  input  1  high for ≥1 cycle: new packet begins (SYNC seen); clears receive state
rx_finish  input  1  1-cycle pulse: EOP seen, packet ended
rx_status  input  1  1-cycle strobe: rx_bit holds one valid unstuffed bit
rx_bit  input  1  received bit, sampled when rx_status=1
rx_packet_pid  output  4  decoded PID (low nibble of PID byte)
rx_packet_addr  output  11  token payload: {endp[3:0], addr[6:0]}, or SOF frame number
rx_packet_byte  output  8  data-packet payload byte
rx_packet_byte_en  output  1  1-cycle strobe: rx_packet_byte valid
rx_packet_valid  output  1  packet good: PID check passed, and CRC and length correct where applicable
rx_packet_fin  output  1  1-cycle pulse: packet complete; rx_packet_valid meaningful

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs and internal state are 0; FSM goes to IDLE. Reset mid-packet aborts the packet without producing rx_packet_fin.
- Bit order: every field is LSB first. Bit k of a field lands in field[k].
- FSM states:
  - IDLE → PID on rx_start.
  - PID: collect 8 bits. After the 8th bit, register rx_packet_pid = byte[3:0] and pid_ok = (byte[7:4] == ~byte[3:0]). Branch on PID[1:0]:
    - 01 (OUT/IN/SOF/SETUP) → TOKEN.
    - 11 (DATA0/1/2, MDATA) → DATA.
    - 10 or 00 (handshake/special) → NOPAYLOAD.
  - TOKEN: 16 bits. First 11 go to an address shift register; rx_packet_addr updates after the 11th. CRC5 (x^5+x^2+1, init 5'b11111) runs over all 16 bits. Good residual = 5'b01100.
  - DATA: CRC16 (x^16+x^15+x^2+1, init 16'hFFFF) runs over all bits. Good residual = 16'h800D. Bytes go through a 2-byte delay line: when byte n (n≥2, 0-based) completes, output byte n-2 with a 1-cycle byte_en, registered, in the cycle after the completing rx_status. The two CRC bytes are therefore never emitted.
  - NOPAYLOAD: any further bits mark the packet bad.
- Residual registers hold the MSB-first shift state (feedback = bit ^ crc[MSB]).
- rx_finish in any non-IDLE state → next cycle rx_packet_fin=1 for 1 cycle and FSM → IDLE. rx_packet_valid is registered in that same cycle:
  - token: pid_ok, exactly 24 bits, CRC5 good.
  - data: pid_ok, total bits ≥24 and a multiple of 8, CRC16 good.
  - nopayload: pid_ok and exactly 8 bits.
  - finish during PID (<8 bits): invalid.
- rx_packet_valid, rx_packet_pid and rx_packet_addr hold until the next rx_start, which clears valid only.
- rx_finish in IDLE: ignored.
- rx_status in IDLE: ignored.
- rx_start during a packet: restarts; no fin.
- rx_start with rx_status in the same cycle: start wins, bit dropped.
- rx_finish with rx_status in the same cycle: bit consumed first, then finish evaluated.
- Bits beyond the expected token length set a length error; no counter wrap (saturating 7-bit bit counter).

Decomposition:
- Package usb_pkg: PID constants (OUT 0001, IN 1001, SOF 0101, SETUP 1101, DATA0 0011, DATA1 1011, DATA2 0111, MDATA 1111, ACK 0010, NAK 1010, STALL 1110, NYET 0110), PID-type encodings, CRC5/CRC16 polynomials, init values and residual constants, FSM state enum.
- One sub-module: usb_crc (parameterised width/poly/init, serial update, clear input), instantiated twice.

Test Plan:
- OUT token: bits 1,0,0,0,0,1,1,1 | 1,1,1,0,0,1,1,0,1,0,1 | 0,1,1,0,0 then rx_finish, with 1-of-5-cycle rx_status → pid=4'b0001, addr=11'b10101100111, fin pulse with valid=1.
- Same token with one CRC bit flipped → fin with valid=0; addr still 11'b10101100111.
- ACK: bits 0,1,0,0,1,0,1,1 then finish → pid=4'b0010, valid=1, no byte_en.
- MDATA: PID bits 1,1,1,1,0,0,0,0, data bytes 0x67, 0x65, 0x8A, then model-computed CRC16 → pid=4'b1111; exactly 3 byte_en strobes carrying 0x67, 0x65, 0x8A in order; valid=1. With a corrupted CRC → same bytes, valid=0.
- Bad PID byte 0x00 (nibble check fails) followed by finish → valid=0. A 5-bit packet followed by finish → valid=0.
- rx_start mid-token, then a full ACK → no fin for the aborted packet; ACK reported valid. Reset asserted mid-data → all outputs 0.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB packet-layer constants: PID codes, PID type encodings, CRC
// polynomials/init/residual values, field lengths and receiver FSM states.
package usb_pkg;

    localparam int unsigned PID_W  = 4;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ST_W   = 3;

    // Token PIDs
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    // Data PIDs
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    // Handshake PIDs
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    // PID[1:0] selects the packet class
    localparam logic [1:0] PID_TYPE_SPECIAL   = 2'b00;
    localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
    localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;
    localparam logic [1:0] PID_TYPE_DATA      = 2'b11;

    localparam int unsigned  CRC5_W        = 5;
    localparam logic [4:0]   CRC5_POLY     = 5'b00101;
    localparam logic [4:0]   CRC5_INIT     = 5'b11111;
    localparam logic [4:0]   CRC5_RESIDUAL = 5'b01100;

    localparam int unsigned  CRC16_W        = 16;
    localparam logic [15:0]  CRC16_POLY     = 16'h8005;
    localparam logic [15:0]  CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0]  CRC16_RESIDUAL = 16'h800D;

    // Packet lengths in bits, PID included
    localparam int unsigned PID_BITS        = 8;
    localparam int unsigned TOKEN_BITS      = 24;
    localparam int unsigned DATA_MIN_BITS   = 24;
    // bit_cnt value while the last address bit is being received
    localparam int unsigned TOKEN_ADDR_LAST = PID_BITS + ADDR_W - 1;

    // Receiver FSM states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PID       = 3'd1;
    localparam logic [2:0] ST_TOKEN     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_NOPAYLOAD = 3'd4;

    // Upper nibble of a PID byte must be the complement of the lower nibble
    function automatic logic pid_check(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_crc.sv
// Serial MSB-first CRC shift register.
// Ports: clk, rst_n (sync, active-low); clear loads INIT; en shifts bit_in in;
// crc is the registered state, crc_next_c the combinational state after bit_in.
module usb_crc
    import usb_pkg::*;
#(
    parameter int unsigned      WIDTH = CRC5_W,
    parameter logic [WIDTH-1:0] POLY  = CRC5_POLY,
    parameter logic [WIDTH-1:0] INIT  = CRC5_INIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc,
    output logic [WIDTH-1:0] crc_next_c
);

    logic feedback;

    // One LFSR step: feedback = incoming bit xor current MSB
    always_comb begin
        feedback   = bit_in ^ crc[WIDTH-1];
        crc_next_c = {crc[WIDTH-2:0], 1'b0};
        if (feedback) begin
            crc_next_c = crc_next_c ^ POLY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= INIT;
        end else if (en) begin
            crc <= crc_next_c;
        end
    end

endmodule

// File: rtl/usb_packet_rx.sv
// USB packet-layer receiver: assembles the LSB-first unstuffed bit stream,
// checks the PID, extracts token address/endpoint, streams data bytes through
// a 2-byte delay line (so CRC bytes are never emitted) and reports validity.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_start            SYNC seen, (re)starts a packet
//   rx_finish           EOP seen, packet ended
//   rx_status, rx_bit   one valid received bit per strobe
//   rx_packet_pid       decoded PID nibble
//   rx_packet_addr      token payload {endp, addr} / SOF frame number
//   rx_packet_byte(_en) data payload byte and its 1-cycle strobe
//   rx_packet_valid     packet good, meaningful with rx_packet_fin
//   rx_packet_fin       1-cycle packet-complete pulse
module usb_packet_rx
    import usb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_start,
    input  logic                rx_finish,
    input  logic                rx_status,
    input  logic                rx_bit,
    output logic [PID_W-1:0]    rx_packet_pid,
    output logic [ADDR_W-1:0]   rx_packet_addr,
    output logic [BYTE_W-1:0]   rx_packet_byte,
    output logic                rx_packet_byte_en,
    output logic                rx_packet_valid,
    output logic                rx_packet_fin
);

    logic [ST_W-1:0]    state;
    logic [ST_W-1:0]    state_next;
    logic [ST_W-1:0]    state_eff_c;
    logic [ST_W-1:0]    pid_branch_c;

    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt_eff_c;
    logic [2:0]         bit_idx;
    logic [2:0]         idx_eff_c;
    logic [BYTE_W-1:0]  shift_sr;
    logic [BYTE_W-1:0]  byte_c;
    logic [ADDR_W-1:0]  addr_sr;
    logic               pid_ok;
    logic               pid_ok_c;
    logic [1:0]         data_cnt;
    logic [BYTE_W-1:0]  dly0;
    logic [BYTE_W-1:0]  dly1;

    logic               take_c;
    logic               finish_c;
    logic               pid_done_c;
    logic               byte_done_c;
    logic               valid_c;

    logic [CRC5_W-1:0]  crc5;
    logic [CRC5_W-1:0]  crc5_next_c;
    logic [CRC5_W-1:0]  crc5_eff_c;
    logic [CRC16_W-1:0] crc16;
    logic [CRC16_W-1:0] crc16_next_c;
    logic [CRC16_W-1:0] crc16_eff_c;

    usb_crc #(
        .WIDTH (CRC5_W),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (rx_start),
        .en         (take_c && (state == ST_TOKEN)),
        .bit_in     (rx_bit),
        .crc        (crc5),
        .crc_next_c (crc5_next_c)
    );

    usb_crc #(
        .WIDTH (CRC16_W),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (rx_start),
        .en         (take_c && (state == ST_DATA)),
        .bit_in     (rx_bit),
        .crc        (crc16),
        .crc_next_c (crc16_next_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the "after this cycle's bit" view used to judge a
    // finish that arrives together with the last bit
    always_comb begin
        take_c      = rx_status && !rx_start && (state != ST_IDLE);
        finish_c    = rx_finish && !rx_start && (state != ST_IDLE);
        byte_c      = {rx_bit, shift_sr[BYTE_W-1:1]};
        pid_done_c  = take_c && (state == ST_PID) && (bit_cnt == CNT_W'(PID_BITS - 1));
        byte_done_c = take_c && (state == ST_DATA) && (bit_idx == 3'd7);

        cnt_eff_c = bit_cnt;
        if (take_c && (bit_cnt != '1)) begin
            cnt_eff_c = bit_cnt + CNT_W'(1);
        end
        idx_eff_c = take_c ? (bit_idx + 3'd1) : bit_idx;
        pid_ok_c  = pid_done_c ? pid_check(byte_c) : pid_ok;

        case (byte_c[1:0])
            PID_TYPE_TOKEN: pid_branch_c = ST_TOKEN;
            PID_TYPE_DATA:  pid_branch_c = ST_DATA;
            default:        pid_branch_c = ST_NOPAYLOAD;
        endcase
        state_eff_c = pid_done_c ? pid_branch_c : state;

        crc5_eff_c  = (take_c && (state == ST_TOKEN)) ? crc5_next_c  : crc5;
        crc16_eff_c = (take_c && (state == ST_DATA))  ? crc16_next_c : crc16;

        valid_c = 1'b0;
        case (state_eff_c)
            ST_TOKEN: valid_c = pid_ok_c && (cnt_eff_c == CNT_W'(TOKEN_BITS))
                                && (crc5_eff_c == CRC5_RESIDUAL);
            ST_DATA: valid_c = pid_ok_c && (cnt_eff_c >= CNT_W'(DATA_MIN_BITS))
                               && (idx_eff_c == 3'd0)
                               && (crc16_eff_c == CRC16_RESIDUAL);
            ST_NOPAYLOAD: valid_c = pid_ok_c && (cnt_eff_c == CNT_W'(PID_BITS));
            default: valid_c = 1'b0;
        endcase

        state_next = state_eff_c;
        if (rx_start) begin
            state_next = ST_PID;
        end else if (finish_c) begin
            state_next = ST_IDLE;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt           <= '0;
            bit_idx           <= '0;
            shift_sr          <= '0;
            addr_sr           <= '0;
            pid_ok            <= 1'b0;
            data_cnt          <= '0;
            dly0              <= '0;
            dly1              <= '0;
            rx_packet_pid     <= '0;
            rx_packet_addr    <= '0;
            rx_packet_byte    <= '0;
            rx_packet_byte_en <= 1'b0;
            rx_packet_valid   <= 1'b0;
            rx_packet_fin     <= 1'b0;
        end else begin
            rx_packet_fin     <= 1'b0;
            rx_packet_byte_en <= 1'b0;
            if (rx_start) begin
                bit_cnt         <= '0;
                bit_idx         <= '0;
                shift_sr        <= '0;
                addr_sr         <= '0;
                pid_ok          <= 1'b0;
                data_cnt        <= '0;
                dly0            <= '0;
                dly1            <= '0;
                rx_packet_valid <= 1'b0;
            end else begin
                if (take_c) begin
                    bit_cnt  <= cnt_eff_c;
                    bit_idx  <= idx_eff_c;
                    shift_sr <= byte_c;
                end
                if (take_c && (state == ST_TOKEN)) begin
                    addr_sr <= {rx_bit, addr_sr[ADDR_W-1:1]};
                    if (bit_cnt == CNT_W'(TOKEN_ADDR_LAST)) begin
                        rx_packet_addr <= {rx_bit, addr_sr[ADDR_W-1:1]};
                    end
                end
                if (pid_done_c) begin
                    rx_packet_pid <= byte_c[PID_W-1:0];
                    pid_ok        <= pid_ok_c;
                end
                // Two-byte delay line: the trailing CRC16 bytes stay behind
                if (byte_done_c) begin
                    if (data_cnt == 2'd2) begin
                        rx_packet_byte    <= dly1;
                        rx_packet_byte_en <= 1'b1;
                    end else begin
                        data_cnt <= data_cnt + 2'd1;
                    end
                    dly1 <= dly0;
                    dly0 <= byte_c;
                end
                if (finish_c) begin
                    rx_packet_fin   <= 1'b1;
                    rx_packet_valid <= valid_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_packet_rx.sv
// Directed self-checking bench for usb_packet_rx.
module tb_usb_packet_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_start;
    logic        rx_finish;
    logic        rx_status;
    logic        rx_bit;
    logic [3:0]  rx_packet_pid;
    logic [10:0] rx_packet_addr;
    logic [7:0]  rx_packet_byte;
    logic        rx_packet_byte_en;
    logic        rx_packet_valid;
    logic        rx_packet_fin;

    int          checks = 0;
    int          errors = 0;
    int          fin_cnt = 0;
    logic        fin_valid = 1'b0;
    logic [7:0]  got[$];

    // OUT token, bit k of the vector is the k-th bit on the wire
    localparam logic [23:0] OUT_TOKEN = {5'b00110, 11'b10101100111, 8'hE1};

    always #5 clk = ~clk;

    usb_packet_rx dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_start          (rx_start),
        .rx_finish         (rx_finish),
        .rx_status         (rx_status),
        .rx_bit            (rx_bit),
        .rx_packet_pid     (rx_packet_pid),
        .rx_packet_addr    (rx_packet_addr),
        .rx_packet_byte    (rx_packet_byte),
        .rx_packet_byte_en (rx_packet_byte_en),
        .rx_packet_valid   (rx_packet_valid),
        .rx_packet_fin     (rx_packet_fin)
    );

    // Output monitor on the inactive edge
    always @(negedge clk) begin
        if (rx_packet_fin) begin
            fin_cnt   <= fin_cnt + 1;
            fin_valid <= rx_packet_valid;
        end
        if (rx_packet_byte_en) begin
            got.push_back(rx_packet_byte);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reflected-form USB CRC16; returns the value as transmitted (inverted)
    function automatic logic [15:0] crc16_of(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2);
        logic [15:0] c;
        logic [7:0]  d [3];
        d[0] = b0; d[1] = b1; d[2] = b2;
        c = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            c = c ^ {8'h00, d[i]};
            for (int j = 0; j < 8; j++) begin
                if (c[0]) c = (c >> 1) ^ 16'hA001;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        rx_status = 1'b1;
        rx_bit    = b;
        cyc(1);
        rx_status = 1'b0;
        rx_bit    = 1'b0;
        cyc(gap);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 0; i < 8; i++) send_bit(v[i], gap);
    endtask

    task automatic start_pkt();
        rx_start = 1'b1;
        cyc(1);
        rx_start = 1'b0;
        cyc(1);
    endtask

    task automatic finish_pkt();
        rx_finish = 1'b1;
        cyc(1);
        rx_finish = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        int f0;
        rst_n = 1'b0;
        cyc(3);
        checks++; if (rx_packet_pid !== 4'h0) begin errors++; $display("FAIL reset_pid: got %h expected 0", rx_packet_pid); end
        checks++; if (rx_packet_addr !== 11'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", rx_packet_addr); end
        checks++; if ({rx_packet_byte, rx_packet_byte_en, rx_packet_valid, rx_packet_fin} !== 11'h0) begin
            errors++; $display("FAIL reset_flags: got %h expected 0", {rx_packet_byte, rx_packet_byte_en, rx_packet_valid, rx_packet_fin});
        end
        rst_n = 1'b1;
        cyc(2);
        // Finish and bits in IDLE are ignored
        f0 = fin_cnt;
        rx_finish = 1'b1; rx_status = 1'b1; rx_bit = 1'b1;
        cyc(1);
        rx_finish = 1'b0; rx_status = 1'b0; rx_bit = 1'b0;
        cyc(3);
        checks++; if (fin_cnt !== f0) begin errors++; $display("FAIL idle_finish: got %0d fins expected %0d", fin_cnt, f0); end
    endtask

    task automatic run_token(input logic [23:0] tok, input logic exp_valid, input string tag);
        int f0;
        f0 = fin_cnt;
        got.delete();
        start_pkt();
        for (int i = 0; i < 24; i++) send_bit(tok[i], 4);
        finish_pkt();
        checks++; if (fin_cnt !== f0 + 1) begin errors++; $display("FAIL %s_fin: got %0d fins expected %0d", tag, fin_cnt - f0, 1); end
        checks++; if (fin_valid !== exp_valid) begin errors++; $display("FAIL %s_valid: got %b expected %b", tag, fin_valid, exp_valid); end
        checks++; if (rx_packet_pid !== 4'b0001) begin errors++; $display("FAIL %s_pid: got %b expected 0001", tag, rx_packet_pid); end
        checks++; if (rx_packet_addr !== 11'b10101100111) begin errors++; $display("FAIL %s_addr: got %b expected 10101100111", tag, rx_packet_addr); end
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL %s_bytes: got %0d byte strobes expected 0", tag, got.size()); end
    endtask

    task automatic test_out_token();
        run_token(OUT_TOKEN, 1'b1, "out_token");
    endtask

    task automatic test_token_bad_crc();
        logic [23:0] tok;
        tok = OUT_TOKEN;
        tok[23] = ~tok[23];
        // A new start clears valid but keeps pid/addr
        rx_start = 1'b1;
        cyc(1);
        checks++; if (rx_packet_valid !== 1'b0) begin errors++; $display("FAIL start_clears_valid: got %b expected 0", rx_packet_valid); end
        checks++; if (rx_packet_pid !== 4'b0001) begin errors++; $display("FAIL start_keeps_pid: got %b expected 0001", rx_packet_pid); end
        rx_start = 1'b0;
        run_token(tok, 1'b0, "bad_crc_token");
    endtask

    task automatic test_ack();
        int f0;
        f0 = fin_cnt;
        got.delete();
        start_pkt();
        send_byte(8'hD2, 1);
        finish_pkt();
        checks++; if (fin_cnt !== f0 + 1) begin errors++; $display("FAIL ack_fin: got %0d fins expected 1", fin_cnt - f0); end
        checks++; if (fin_valid !== 1'b1) begin errors++; $display("FAIL ack_valid: got %b expected 1", fin_valid); end
        checks++; if (rx_packet_pid !== 4'b0010) begin errors++; $display("FAIL ack_pid: got %b expected 0010", rx_packet_pid); end
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL ack_bytes: got %0d strobes expected 0", got.size()); end
        // Last bit arrives in the same cycle as finish: bit counts first
        f0 = fin_cnt;
        start_pkt();
        for (int i = 0; i < 7; i++) send_bit(1'(8'hD2 >> i), 1);
        rx_status = 1'b1; rx_bit = 1'b1; rx_finish = 1'b1;
        cyc(1);
        rx_status = 1'b0; rx_bit = 1'b0; rx_finish = 1'b0;
        cyc(2);
        checks++; if (fin_cnt !== f0 + 1) begin errors++; $display("FAIL ack_same_cycle_fin: got %0d fins expected 1", fin_cnt - f0); end
        checks++; if (fin_valid !== 1'b1) begin errors++; $display("FAIL ack_same_cycle_valid: got %b expected 1", fin_valid); end
    endtask

    task automatic run_mdata(input logic corrupt, input string tag);
        logic [15:0] crc;
        logic [7:0]  exp_b [3];
        int          f0;
        exp_b[0] = 8'h67; exp_b[1] = 8'h65; exp_b[2] = 8'h8A;
        crc = crc16_of(exp_b[0], exp_b[1], exp_b[2]);
        if (corrupt) crc[3] = ~crc[3];
        f0 = fin_cnt;
        got.delete();
        start_pkt();
        send_byte(8'h0F, 1);
        for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1);
        send_byte(crc[7:0], 1);
        send_byte(crc[15:8], 1);
        finish_pkt();
        checks++; if (fin_cnt !== f0 + 1) begin errors++; $display("FAIL %s_fin: got %0d fins expected 1", tag, fin_cnt - f0); end
        checks++; if (fin_valid !== !corrupt) begin errors++; $display("FAIL %s_valid: got %b expected %b", tag, fin_valid, !corrupt); end
        checks++; if (rx_packet_pid !== 4'b1111) begin errors++; $display("FAIL %s_pid: got %b expected 1111", tag, rx_packet_pid); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL %s_count: got %0d strobes expected 3", tag, got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL %s_byte%0d: got %h expected %h", tag, i, got[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_mdata();
        run_mdata(1'b0, "mdata");
        run_mdata(1'b1, "mdata_bad_crc");
    endtask

    task automatic test_bad_lengths();
        int f0;
        f0 = fin_cnt;
        start_pkt();
        send_byte(8'h00, 1);
        finish_pkt();
        checks++; if (fin_cnt !== f0 + 1) begin errors++; $display("FAIL bad_pid_fin: got %0d fins expected 1", fin_cnt - f0); end
        checks++; if (fin_valid !== 1'b0) begin errors++; $display("FAIL bad_pid_valid: got %b expected 0", fin_valid); end
        checks++; if (rx_packet_pid !== 4'b0000) begin errors++; $display("FAIL bad_pid_pid: got %b expected 0000", rx_packet_pid); end
        f0 = fin_cnt;
        start_pkt();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
        finish_pkt();
        checks++; if (fin_cnt !== f0 + 1) begin errors++; $display("FAIL short_fin: got %0d fins expected 1", fin_cnt - f0); end
        checks++; if (fin_valid !== 1'b0) begin errors++; $display("FAIL short_valid: got %b expected 0", fin_valid); end
        // ACK followed by an extra bit is too long
        f0 = fin_cnt;
        start_pkt();
        send_byte(8'hD2, 1);
        send_bit(1'b0, 1);
        finish_pkt();
        checks++; if (fin_valid !== 1'b0 || fin_cnt !== f0 + 1) begin errors++; $display("FAIL long_ack: got valid %b fins %0d expected valid 0 fins 1", fin_valid, fin_cnt - f0); end
    endtask

    task automatic test_restart();
        int f0;
        f0 = fin_cnt;
        start_pkt();
        for (int i = 0; i < 14; i++) send_bit(OUT_TOKEN[i], 1);
        start_pkt();
        send_byte(8'hD2, 1);
        finish_pkt();
        checks++; if (fin_cnt !== f0 + 1) begin errors++; $display("FAIL restart_fin: got %0d fins expected 1", fin_cnt - f0); end
        checks++; if (fin_valid !== 1'b1) begin errors++; $display("FAIL restart_valid: got %b expected 1", fin_valid); end
        checks++; if (rx_packet_pid !== 4'b0010) begin errors++; $display("FAIL restart_pid: got %b expected 0010", rx_packet_pid); end
    endtask

    task automatic test_reset_mid_data();
        int f0;
        f0 = fin_cnt;
        got.delete();
        start_pkt();
        send_byte(8'h0F, 1);
        send_byte(8'h67, 1);
        send_byte(8'h65, 1);
        send_byte(8'h8A, 1);
        send_bit(1'b1, 1);
        rst_n = 1'b0;
        cyc(1);
        checks++; if ({rx_packet_pid, rx_packet_addr, rx_packet_byte} !== 23'h0) begin
            errors++; $display("FAIL midreset_data: got %h expected 0", {rx_packet_pid, rx_packet_addr, rx_packet_byte});
        end
        checks++; if ({rx_packet_byte_en, rx_packet_valid, rx_packet_fin} !== 3'b000) begin
            errors++; $display("FAIL midreset_flags: got %b expected 000", {rx_packet_byte_en, rx_packet_valid, rx_packet_fin});
        end
        rst_n = 1'b1;
        rx_finish = 1'b1;
        cyc(1);
        rx_finish = 1'b0;
        cyc(3);
        checks++; if (fin_cnt !== f0) begin errors++; $display("FAIL midreset_nofin: got %0d fins expected 0", fin_cnt - f0); end
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_start  = 1'b0;
        rx_finish = 1'b0;
        rx_status = 1'b0;
        rx_bit    = 1'b0;
        test_reset();
        test_out_token();
        test_token_bad_crc();
        test_ack();
        test_mdata();
        test_bad_lengths();
        test_restart();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
